// File: rtl/sram_sched_pkg.sv
// Shared constants for the SRAM access scheduler: widths, timing limits,
// FSM state encoding and controller rw encoding.
package sram_sched_pkg;

    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned VEC_W      = 16;
    localparam int unsigned IMC_CYCLES = 8;
    localparam int unsigned TIMEOUT    = 15;
    localparam int unsigned STATE_W    = 3;

    localparam logic [STATE_W-1:0] S_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] S_MEM_LAUNCH = 3'd1;
    localparam logic [STATE_W-1:0] S_MEM_WAIT   = 3'd2;
    localparam logic [STATE_W-1:0] S_IMC_RUN    = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE       = 3'd4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic OWNER_MEM = 1'b0;
    localparam logic OWNER_IMC = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Index 0 is the memory port, index 1 the IMC port;
// after every grant the pointer moves to the requester that did not win.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt_onehot_c
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_onehot_c = req;
        if (req == 2'b11) begin
            gnt_onehot_c = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        if (advance && (gnt_onehot_c != 2'b00)) begin
            ptr_d = gnt_onehot_c[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_access_scheduler.sv
// Shares one SRAM macro controller between a memory port and an IMC port,
// holding the controller inputs stable for the whole operation.
module sram_access_scheduler
    import sram_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              mem_gnt,
    output logic              mem_done,
    input  logic              imc_req,
    input  logic [VEC_W-1:0]  imc_vec,
    output logic              imc_gnt,
    output logic              imc_done,
    output logic              ctl_rw,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic              ctl_en_dec,
    output logic              ctl_mem_en,
    output logic              ctl_imc_en,
    output logic [VEC_W-1:0]  ctl_ib,
    input  logic              ctl_halt,
    output logic              sched_busy,
    output logic              err_timeout,
    input  logic              err_clr
);

    localparam int unsigned CNT_MAX = (TIMEOUT > IMC_CYCLES) ? TIMEOUT : IMC_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic               mem_gnt_q, mem_gnt_d, mem_done_q, mem_done_d;
    logic               imc_gnt_q, imc_gnt_d, imc_done_q, imc_done_d;
    logic               ctl_rw_q, ctl_rw_d;
    logic [ADDR_W-1:0]  ctl_addr_q, ctl_addr_d;
    logic               ctl_en_dec_q, ctl_en_dec_d;
    logic               ctl_mem_en_q, ctl_mem_en_d;
    logic               ctl_imc_en_q, ctl_imc_en_d;
    logic [VEC_W-1:0]   ctl_ib_q, ctl_ib_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               finish_c;
    logic               arb_adv_c;
    logic [1:0]         arb_req_c;
    logic [1:0]         arb_gnt_c;

    assign arb_req_c = {imc_req, mem_req};

    rr_arbiter2 u_arb (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (arb_req_c),
        .advance      (arb_adv_c),
        .gnt_onehot_c (arb_gnt_c)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
        owner_d      = owner_q;
        mem_gnt_d    = 1'b0;
        mem_done_d   = 1'b0;
        imc_gnt_d    = 1'b0;
        imc_done_d   = 1'b0;
        ctl_rw_d     = ctl_rw_q;
        ctl_addr_d   = ctl_addr_q;
        ctl_en_dec_d = ctl_en_dec_q;
        ctl_mem_en_d = ctl_mem_en_q;
        ctl_imc_en_d = ctl_imc_en_q;
        ctl_ib_d     = ctl_ib_q;
        busy_d       = busy_q;
        err_d        = err_clr ? 1'b0 : err_q;
        finish_c     = 1'b0;
        arb_adv_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (arb_gnt_c != 2'b00) begin
                    arb_adv_c = 1'b1;
                    busy_d    = 1'b1;
                    if (arb_gnt_c[0]) begin
                        state_d      = S_MEM_LAUNCH;
                        owner_d      = OWNER_MEM;
                        mem_gnt_d    = 1'b1;
                        ctl_rw_d     = mem_rw;
                        ctl_addr_d   = mem_addr;
                        ctl_mem_en_d = 1'b1;
                        ctl_en_dec_d = 1'b1;
                        ctl_imc_en_d = 1'b0;
                    end else begin
                        state_d      = S_IMC_RUN;
                        owner_d      = OWNER_IMC;
                        imc_gnt_d    = 1'b1;
                        ctl_ib_d     = imc_vec;
                        ctl_imc_en_d = 1'b1;
                        ctl_mem_en_d = 1'b0;
                        ctl_en_dec_d = 1'b0;
                    end
                end
            end
            S_MEM_LAUNCH: begin
                if (ctl_halt) begin
                    state_d = S_MEM_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    finish_c = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (!ctl_halt) begin
                    finish_c = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    finish_c = 1'b1;
                end
            end
            S_IMC_RUN: begin
                // Fixed-length sequence; controller halt is irrelevant here.
                if (cnt_q == CNT_W'(IMC_CYCLES - 1)) begin
                    finish_c = 1'b1;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                busy_d     = 1'b0;
                mem_done_d = (owner_q == OWNER_MEM);
                imc_done_d = (owner_q == OWNER_IMC);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish_c) begin
            state_d      = S_DONE;
            cnt_d        = '0;
            ctl_mem_en_d = 1'b0;
            ctl_imc_en_d = 1'b0;
            ctl_en_dec_d = 1'b0;
            ctl_rw_d     = RW_READ;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            owner_q      <= OWNER_MEM;
            mem_gnt_q    <= 1'b0;
            mem_done_q   <= 1'b0;
            imc_gnt_q    <= 1'b0;
            imc_done_q   <= 1'b0;
            ctl_rw_q     <= RW_READ;
            ctl_addr_q   <= '0;
            ctl_en_dec_q <= 1'b0;
            ctl_mem_en_q <= 1'b0;
            ctl_imc_en_q <= 1'b0;
            ctl_ib_q     <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            mem_gnt_q    <= mem_gnt_d;
            mem_done_q   <= mem_done_d;
            imc_gnt_q    <= imc_gnt_d;
            imc_done_q   <= imc_done_d;
            ctl_rw_q     <= ctl_rw_d;
            ctl_addr_q   <= ctl_addr_d;
            ctl_en_dec_q <= ctl_en_dec_d;
            ctl_mem_en_q <= ctl_mem_en_d;
            ctl_imc_en_q <= ctl_imc_en_d;
            ctl_ib_q     <= ctl_ib_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign mem_gnt     = mem_gnt_q;
    assign mem_done    = mem_done_q;
    assign imc_gnt     = imc_gnt_q;
    assign imc_done    = imc_done_q;
    assign ctl_rw      = ctl_rw_q;
    assign ctl_addr    = ctl_addr_q;
    assign ctl_en_dec  = ctl_en_dec_q;
    assign ctl_mem_en  = ctl_mem_en_q;
    assign ctl_imc_en  = ctl_imc_en_q;
    assign ctl_ib      = ctl_ib_q;
    assign sched_busy  = busy_q;
    assign err_timeout = err_q;

endmodule
